// File: rtl/qeciphy_pkg.sv
// qeciphy_pkg: shared constants, types and helpers for the QECi PHY RX path.
//   BYTE_ALIGNMENT_COMMA / WORD_ALIGNMENT_COMMA : comma bytes that make up a FAW
//   faw_state_t                                 : FAW aligner FSM states
//   is_faw_w(data, nb)                          : width-generic FAW check on an aligned word
package qeciphy_pkg;

  localparam logic [7:0] BYTE_ALIGNMENT_COMMA = 8'hBC;
  localparam logic [7:0] WORD_ALIGNMENT_COMMA = 8'hCB;

  // Widest word is_faw_w accepts; narrower words are zero-extended by the caller.
  localparam int FAW_MAX_W = 1024;

  typedef enum logic [1:0] {FAW_HUNT, FAW_VERIFY, FAW_LOCKED} faw_state_t;

  // A FAW has the byte comma in byte 0 and the word comma in byte nb/2.
  function automatic logic is_faw_w(input logic [FAW_MAX_W-1:0] data, input int nb);
    logic [FAW_MAX_W-1:0] hi;
    hi = data >> (8 * (nb / 2));
    return (data[7:0] == BYTE_ALIGNMENT_COMMA) && (hi[7:0] == WORD_ALIGNMENT_COMMA);
  endfunction

endpackage

// File: rtl/qeciphy_faw_matcher.sv
// qeciphy_faw_matcher: combinational FAW search across every byte offset.
//   win_i   : {current word, previous word}, 2*DATA_W bits
//   match_o : bit k set when candidate k (win_i[8k +: DATA_W]) is a FAW
//   any_o   : at least one candidate matches
//   idx_o   : lowest matching k (0 when none)
module qeciphy_faw_matcher
  import qeciphy_pkg::*;
#(
  parameter int DATA_W = 64,
  localparam int NB    = DATA_W / 8,
  localparam int OFF_W = $clog2(NB)
) (
  input  logic [2*DATA_W-1:0] win_i,
  output logic [NB-1:0]       match_o,
  output logic                any_o,
  output logic [OFF_W-1:0]    idx_o
);

  for (genvar k = 0; k < NB; k++) begin : g_lane
    logic [FAW_MAX_W-1:0] cand_ext;
    always_comb begin
      cand_ext              = '0;
      cand_ext[DATA_W-1:0]  = win_i[8*k +: DATA_W];
    end
    assign match_o[k] = is_faw_w(cand_ext, NB);
  end

  // Scan from the top so the lowest matching lane is the last one written.
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    for (int k = NB - 1; k >= 0; k--) begin
      if (match_o[k]) begin
        any_o = 1'b1;
        idx_o = OFF_W'(k);
      end
    end
  end

endmodule

// File: rtl/qeciphy_faw_aligner.sv
// qeciphy_faw_aligner: FAW hunter/locker between byte alignment and the deframer.
//   Searches all byte offsets of the RX stream, realigns words to the FAW
//   boundary, locks after LOCK_CNT periodic FAWs, unlocks after UNLOCK_CNT misses.
// Ports:
//   clk, rst         : core clock, synchronous active-high reset
//   rx_data_i/valid  : byte-aligned, word-unaligned RX data
//   force_hunt_i     : level request to return to HUNT
//   aligned_data_o   : word-aligned data, 1 cycle latency, qualified by aligned_valid_o
//   faw_o            : aligned word is a FAW at an expected slot
//   locked_o         : in LOCKED
//   offset_o         : selected byte offset
//   lock_loss_o      : 1-cycle pulse on leaving LOCKED
// Build option QECIPHY_FAW_STATS_EN adds faw_miss_cnt_o and relock_cnt_o
// (saturating 16-bit counters, cleared only by rst).
module qeciphy_faw_aligner
  import qeciphy_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int FAW_PERIOD = 64,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_W-1:0]            rx_data_i,
  input  logic                         rx_valid_i,
  input  logic                         force_hunt_i,
  output logic [DATA_W-1:0]            aligned_data_o,
  output logic                         aligned_valid_o,
  output logic                         faw_o,
  output logic                         locked_o,
  output logic [$clog2(DATA_W/8)-1:0]  offset_o,
  output logic                         lock_loss_o
`ifdef QECIPHY_FAW_STATS_EN
  ,
  output logic [15:0]                  faw_miss_cnt_o,
  output logic [15:0]                  relock_cnt_o
`endif
);

  localparam int NB     = DATA_W / 8;
  localparam int OFF_W  = $clog2(NB);
  localparam int PER_W  = $clog2(FAW_PERIOD);
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);

  faw_state_t           state_q, state_d;
  logic [DATA_W-1:0]    prev_q;
  logic [OFF_W-1:0]     offset_q, offset_d;
  logic [PER_W-1:0]     period_q, period_d;
  logic [GOOD_W-1:0]    good_q, good_d;
  logic [BAD_W-1:0]     bad_q, bad_d;
  logic [DATA_W-1:0]    aligned_data_q;
  logic                 aligned_valid_q, faw_q, faw_d, lock_loss_q, lock_loss_d;
  logic                 miss_inc, relock_inc;

  logic [2*DATA_W-1:0]  win, win_sh;
  logic [NB-1:0]        match;
  logic                 any_match;
  logic [OFF_W-1:0]     first_idx;
  logic                 slot, slot_hit;

  assign win    = {rx_data_i, prev_q};
  assign win_sh = win >> {offset_q, 3'b000};

  qeciphy_faw_matcher #(.DATA_W(DATA_W)) u_matcher (
    .win_i   (win),
    .match_o (match),
    .any_o   (any_match),
    .idx_o   (first_idx)
  );

  // The selected lane's match bit is exactly the candidate[offset] FAW check.
  assign slot     = (32'(period_q) == FAW_PERIOD - 1);
  assign slot_hit = match[offset_q];

  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    period_d    = period_q;
    good_d      = good_q;
    bad_d       = bad_q;
    lock_loss_d = 1'b0;
    miss_inc    = 1'b0;
    relock_inc  = 1'b0;
    // Reported even when force_hunt_i overrides the state change.
    faw_d       = rx_valid_i && (state_q != FAW_HUNT) && slot && slot_hit;

    if (force_hunt_i) begin
      state_d     = FAW_HUNT;
      period_d    = '0;
      good_d      = '0;
      bad_d       = '0;
      lock_loss_d = (state_q == FAW_LOCKED);
    end else if (rx_valid_i) begin
      case (state_q)
        FAW_HUNT: begin
          if (any_match) begin
            offset_d = first_idx;
            period_d = '0;
            good_d   = GOOD_W'(1);
            bad_d    = '0;
            state_d  = (LOCK_CNT == 1) ? FAW_LOCKED : FAW_VERIFY;
          end
        end
        FAW_VERIFY: begin
          if (!slot) begin
            period_d = period_q + 1'b1;
          end else if (slot_hit) begin
            period_d = '0;
            good_d   = good_q + 1'b1;
            if (32'(good_q) + 32'd1 >= LOCK_CNT) begin
              state_d    = FAW_LOCKED;
              bad_d      = '0;
              relock_inc = 1'b1;
            end
          end else begin
            state_d  = FAW_HUNT;
            period_d = '0;
            good_d   = '0;
          end
        end
        FAW_LOCKED: begin
          if (!slot) begin
            period_d = period_q + 1'b1;
          end else begin
            period_d = '0;
            if (slot_hit) begin
              bad_d = '0;
            end else begin
              miss_inc = 1'b1;
              if (32'(bad_q) + 32'd1 >= UNLOCK_CNT) begin
                state_d     = FAW_HUNT;
                lock_loss_d = 1'b1;
                bad_d       = '0;
                good_d      = '0;
              end else begin
                bad_d = bad_q + 1'b1;
              end
            end
          end
        end
        default: state_d = FAW_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= FAW_HUNT;
      prev_q          <= '0;
      offset_q        <= '0;
      period_q        <= '0;
      good_q          <= '0;
      bad_q           <= '0;
      aligned_data_q  <= '0;
      aligned_valid_q <= 1'b0;
      faw_q           <= 1'b0;
      lock_loss_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      offset_q        <= offset_d;
      period_q        <= period_d;
      good_q          <= good_d;
      bad_q           <= bad_d;
      aligned_valid_q <= rx_valid_i;
      faw_q           <= faw_d;
      lock_loss_q     <= lock_loss_d;
      if (rx_valid_i) begin
        prev_q         <= rx_data_i;
        aligned_data_q <= win_sh[DATA_W-1:0];
      end
    end
  end

  assign aligned_data_o  = aligned_data_q;
  assign aligned_valid_o = aligned_valid_q;
  assign faw_o           = faw_q;
  assign locked_o        = (state_q == FAW_LOCKED);
  assign offset_o        = offset_q;
  assign lock_loss_o     = lock_loss_q;

`ifdef QECIPHY_FAW_STATS_EN
  logic [15:0] miss_cnt_q, relock_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      miss_cnt_q   <= '0;
      relock_cnt_q <= '0;
    end else begin
      if (miss_inc && (miss_cnt_q != 16'hFFFF))     miss_cnt_q   <= miss_cnt_q + 16'd1;
      if (relock_inc && (relock_cnt_q != 16'hFFFF)) relock_cnt_q <= relock_cnt_q + 16'd1;
    end
  end

  assign faw_miss_cnt_o = miss_cnt_q;
  assign relock_cnt_o   = relock_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = miss_inc ^ relock_inc;
`endif

endmodule

// File: tb/tb_qeciphy_faw_aligner.sv
// tb_qeciphy_faw_aligner: scoreboard bench for qeciphy_faw_aligner (DATA_W=64).
// The RX stream carries logical words shifted by 3 bytes; a FAW appears every
// FAW_PERIOD valid words. A transaction-level model pushes one expected record
// per driven cycle; the monitor pops and compares one cycle later.
// Build option QECIPHY_FAW_STATS_EN also checks the statistics ports.
module tb_qeciphy_faw_aligner;
  localparam int DATA_W = 64, NB = 8, FAW_PERIOD = 64, LOCK_CNT = 4, UNLOCK_CNT = 3;
  localparam int OFS = 3;

  logic clk = 1'b0, rst = 1'b1, rx_valid = 1'b0, force_hunt = 1'b0;
  logic [63:0] rx_data = '0, aligned_data;
  logic aligned_valid, faw, locked, lock_loss;
  logic [2:0] offset;
`ifdef QECIPHY_FAW_STATS_EN
  logic [15:0] miss_cnt, relock_cnt;
`endif

  always #5 clk = ~clk;

  qeciphy_faw_aligner #(.DATA_W(DATA_W), .FAW_PERIOD(FAW_PERIOD), .LOCK_CNT(LOCK_CNT),
                        .UNLOCK_CNT(UNLOCK_CNT)) dut (
    .clk(clk), .rst(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .force_hunt_i(force_hunt), .aligned_data_o(aligned_data), .aligned_valid_o(aligned_valid),
    .faw_o(faw), .locked_o(locked), .offset_o(offset), .lock_loss_o(lock_loss)
`ifdef QECIPHY_FAW_STATS_EN
    , .faw_miss_cnt_o(miss_cnt), .relock_cnt_o(relock_cnt)
`endif
  );

  typedef struct {
    logic [63:0] data;
    logic        valid, faw, locked, loss;
    logic [2:0]  off;
    logic [15:0] miss, relock;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int n_chk = 0, n_pass = 0, loss_seen = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- stimulus stream ----------------
  int wn = 0, phase = 5, corrupt_left = 0;
  logic [63:0] l_prev = '0;

  function automatic logic [63:0] filler(int n);
    logic [63:0] b = '0;
    for (int j = 0; j < 8; j++) b = (b << 8) | 64'((n * 37 + j * 11 + 5) & 127);
    return b;
  endfunction

  task automatic next_rx(output logic [63:0] rx);
    logic [63:0] cur;
    cur = filler(wn);
    if (wn >= phase && ((wn - phase) % FAW_PERIOD) == 0) begin
      if (corrupt_left > 0) corrupt_left--;
      else begin
        cur[7:0]   = 8'hBC;
        cur[39:32] = 8'hCB;
      end
    end
    rx = (cur << (8 * OFS)) | (l_prev >> (8 * (8 - OFS)));
    l_prev = cur;
    wn++;
  endtask

  // ---------------- reference model ----------------
  int m_st = 0, m_off = 0, m_per = 0, m_good = 0, m_bad = 0, m_miss = 0, m_relock = 0;
  logic [63:0] m_prev = '0, m_data = '0;

  function automatic logic [63:0] cand(logic [127:0] w, int k);
    return 64'(w >> (8 * k));
  endfunction

  function automatic logic isfaw(logic [63:0] c);
    return (c[7:0] == 8'hBC) && (c[39:32] == 8'hCB);
  endfunction

  task automatic model(input logic [63:0] d, input logic v, input logic f, input logic r,
                       output exp_t e);
    logic [127:0] w;
    logic [NB-1:0] mt;
    logic slot, hit;
    int k_lo;
    e = '{default: '0};
    if (r) begin
      m_st = 0; m_off = 0; m_per = 0; m_good = 0; m_bad = 0; m_miss = 0; m_relock = 0;
      m_prev = '0; m_data = '0;
      return;
    end
    w = {d, m_prev};
    k_lo = -1;
    for (int k = NB - 1; k >= 0; k--) begin
      mt[k] = isfaw(cand(w, k));
      if (mt[k]) k_lo = k;
    end
    slot = (m_per == FAW_PERIOD - 1);
    hit  = mt[m_off];
    if (v) m_data = cand(w, m_off);
    e.faw = v && (m_st != 0) && slot && hit;
    if (f) begin
      e.loss = (m_st == 2);
      m_st = 0; m_per = 0; m_good = 0; m_bad = 0;
    end else if (v) begin
      case (m_st)
        0: if (k_lo >= 0) begin
             m_off = k_lo; m_per = 0; m_good = 1; m_bad = 0;
             m_st = (LOCK_CNT == 1) ? 2 : 1;
           end
        1: if (!slot) m_per++;
           else if (hit) begin
             m_per = 0; m_good++;
             if (m_good == LOCK_CNT) begin
               m_st = 2; m_bad = 0;
               if (m_relock < 65535) m_relock++;
             end
           end else begin
             m_st = 0; m_per = 0; m_good = 0;
           end
        default: if (!slot) m_per++;
           else begin
             m_per = 0;
             if (hit) m_bad = 0;
             else begin
               m_bad++;
               if (m_miss < 65535) m_miss++;
               if (m_bad == UNLOCK_CNT) begin
                 m_st = 0; e.loss = 1'b1; m_bad = 0; m_good = 0;
               end
             end
           end
      endcase
    end
    if (v) m_prev = d;
    e.valid  = v;
    e.data   = m_data;
    e.locked = (m_st == 2);
    e.off    = 3'(m_off);
    e.miss   = 16'(m_miss);
    e.relock = 16'(m_relock);
  endtask

  // One cycle of stimulus; inputs change on the falling edge.
  task automatic step(input logic v, input logic f, input logic r);
    logic [63:0] d;
    exp_t e;
    @(negedge clk);
    if (v) next_rx(d);
    else d = {$urandom, $urandom};
    rx_data = d; rx_valid = v; force_hunt = f; rst = r;
    model(d, v, f, r, e);
    sb.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(posedge clk);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        #2;
        check("aligned_valid", 64'(aligned_valid), 64'(mon_e.valid));
        check("aligned_data", aligned_data, mon_e.data);
        check("faw", 64'(faw), 64'(mon_e.faw));
        check("locked", 64'(locked), 64'(mon_e.locked));
        check("lock_loss", 64'(lock_loss), 64'(mon_e.loss));
        check("offset", 64'(offset), 64'(mon_e.off));
`ifdef QECIPHY_FAW_STATS_EN
        check("miss_cnt", 64'(miss_cnt), 64'(mon_e.miss));
        check("relock_cnt", 64'(relock_cnt), 64'(mon_e.relock));
`endif
        if (lock_loss) loss_seen++;
        if (faw) begin
          check("faw_byte0", 64'(aligned_data[7:0]), 64'hBC);
          check("faw_byte4", 64'(aligned_data[39:32]), 64'hCB);
        end
      end
    end
  end

  // ---------------- scenarios ----------------
  int l0;
  initial begin
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
    settle();
    check("rst_locked", 64'(locked), 64'd0);
    check("rst_data", aligned_data, 64'd0);

    // Initial lock at byte offset 3.
    run(300);
    settle();
    check("s1_locked", 64'(locked), 64'd1);
    check("s1_offset", 64'(offset), 64'd3);

    // Two corrupted FAWs: lock survives.
    l0 = loss_seen;
    corrupt_left = 2;
    run(FAW_PERIOD * 3 + 10);
    settle();
    check("s2_locked", 64'(locked), 64'd1);
    check("s2_noloss", 64'(loss_seen - l0), 64'd0);

    // Three corrupted FAWs: lock lost once, then regained at the same offset.
    l0 = loss_seen;
    corrupt_left = 3;
    run(FAW_PERIOD * 8);
    settle();
    check("s3_loss", 64'(loss_seen - l0), 64'd1);
    check("s3_relocked", 64'(locked), 64'd1);
    check("s3_offset", 64'(offset), 64'd3);

    // Forced hunt from LOCKED, then move the FAW phase while in VERIFY.
    l0 = loss_seen;
    step(1'b1, 1'b1, 1'b0);
    settle();
    check("s6_force_loss", 64'(loss_seen - l0), 64'd1);
    check("s6_force_unlock", 64'(locked), 64'd0);
    l0 = loss_seen;
    run(70);
    phase = phase + 1;
    run(FAW_PERIOD * 5 + 10);
    settle();
    check("s4_relocked", 64'(locked), 64'd1);
    check("s4_noloss", 64'(loss_seen - l0), 64'd0);

    // Bursty valid while locked.
    l0 = loss_seen;
    for (int i = 0; i < 600; i++) step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    settle();
    check("s5_locked", 64'(locked), 64'd1);
    check("s5_noloss", 64'(loss_seen - l0), 64'd0);

    // Reset in the middle of VERIFY.
    step(1'b1, 1'b1, 1'b0);
    run(100);
    l0 = loss_seen;
    step(1'b1, 1'b0, 1'b1);
    settle();
    check("s6_rst_valid", 64'(aligned_valid), 64'd0);
    check("s6_rst_offset", 64'(offset), 64'd0);
    check("s6_rst_faw", 64'(faw), 64'd0);
    check("s6_rst_locked", 64'(locked), 64'd0);
    check("s6_rst_noloss", 64'(loss_seen - l0), 64'd0);
    run(300);
    settle();
    check("s6_relocked", 64'(locked), 64'd1);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
